// File: rtl/sram_like_pkg.sv
// Shared types and constants for the sram-like arbiter: grant states,
// requester IDs, transfer sizes and the request payload bundle.
package sram_like_pkg;

    typedef enum logic [1:0] {
        FREE      = 2'd0,
        HOLD_INST = 2'd1,
        HOLD_DATA = 2'd2
    } grant_state_e;

    localparam logic ID_INST = 1'b0;
    localparam logic ID_DATA = 1'b1;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } sram_req_t;

endpackage

// File: rtl/sram_like_arbiter_id_fifo.sv
// In-order tag FIFO: remembers which requester issued each outstanding
// transaction so returning data can be steered back to it.
module id_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [PW:0]   count_q;
    logic          push_en;
    logic          pop_en;

    assign full    = (count_q == (PW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign head    = mem_q[rd_ptr_q];
    assign push_en = push && !full;
    assign pop_en  = pop && !empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_en)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_en, pop_en})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; count/pointers alone define validity.
    always_ff @(posedge clk) begin
        if (push_en) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/sram_like_arbiter.sv
// Fixed-priority (data over inst) 2:1 arbiter for sram-like masters onto a
// shared port, with grant hold until addr_ok and in-order return routing.
module sram_like_arbiter
    import sram_like_pkg::*;
#(
    parameter int OUTSTANDING = 4,
    parameter int ID_W        = 1
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        m_req,
    output logic        m_wr,
    output logic [1:0]  m_size,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic        m_addr_ok,
    input  logic        m_data_ok,
    input  logic [31:0] m_rdata
);
    localparam logic [ID_W-1:0] TAG_INST = ID_W'(ID_INST);
    localparam logic [ID_W-1:0] TAG_DATA = ID_W'(ID_DATA);

    grant_state_e    state_q;
    grant_state_e    state_d;
    logic            sel_valid;
    logic [ID_W-1:0] sel_id;
    sram_req_t       inst_bus;
    sram_req_t       data_bus;
    sram_req_t       sel_bus;
    logic            accept;
    logic            fifo_full;
    logic            fifo_empty;
    logic [ID_W-1:0] fifo_head;
    logic            ret_valid;

    assign inst_bus = '{wr: inst_wr, size: inst_size, addr: inst_addr, wdata: inst_wdata};
    assign data_bus = '{wr: data_wr, size: data_size, addr: data_addr, wdata: data_wdata};

    always_ff @(posedge clk) begin
        if (reset) state_q <= FREE;
        else       state_q <= state_d;
    end

    // NOTE: every signal gets a default first so no branch can infer a latch.
    always_comb begin
        sel_valid = 1'b0;
        sel_id    = TAG_INST;
        case (state_q)
            FREE: begin
                if (data_req) begin
                    sel_valid = 1'b1;
                    sel_id    = TAG_DATA;
                end else if (inst_req) begin
                    sel_valid = 1'b1;
                    sel_id    = TAG_INST;
                end
            end
            HOLD_INST: begin
                sel_valid = inst_req;
                sel_id    = TAG_INST;
            end
            HOLD_DATA: begin
                sel_valid = data_req;
                sel_id    = TAG_DATA;
            end
            default: ;
        endcase
    end

    // m_req depends only on requests, grant state and FIFO occupancy, never on m_addr_ok.
    assign m_req  = sel_valid && !fifo_full && !reset;
    assign accept = m_req && m_addr_ok;

    always_comb begin
        sel_bus = '0;
        if (sel_valid) sel_bus = (sel_id == TAG_DATA) ? data_bus : inst_bus;
    end

    assign m_wr    = sel_bus.wr;
    assign m_size  = sel_bus.size;
    assign m_addr  = sel_bus.addr;
    assign m_wdata = sel_bus.wdata;

    assign inst_addr_ok = accept && (sel_id == TAG_INST);
    assign data_addr_ok = accept && (sel_id == TAG_DATA);

    always_comb begin
        state_d = state_q;
        case (state_q)
            FREE: begin
                if (sel_valid && !fifo_full && !m_addr_ok)
                    state_d = (sel_id == TAG_DATA) ? HOLD_DATA : HOLD_INST;
            end
            HOLD_INST, HOLD_DATA: begin
                if (accept) state_d = FREE;
            end
            default: state_d = FREE;
        endcase
    end

    // Returns with nothing outstanding (e.g. stale after reset) are dropped.
    assign ret_valid    = m_data_ok && !fifo_empty && !reset;
    assign inst_data_ok = ret_valid && (fifo_head == TAG_INST);
    assign data_data_ok = ret_valid && (fifo_head == TAG_DATA);
    assign inst_rdata   = m_rdata;
    assign data_rdata   = m_rdata;

    id_fifo #(
        .DEPTH (OUTSTANDING),
        .W     (ID_W)
    ) u_id_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (accept),
        .pop   (ret_valid),
        .din   (sel_id),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (fifo_head)
    );

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Self-checking bench for sram_like_arbiter: directed scenarios followed by
// random traffic, all compared against a queue-based transaction model.
module tb_sram_like_arbiter;
    localparam int OUT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req, inst_wr, data_req, data_wr;
    logic [1:0]  inst_size, data_size, m_size;
    logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [31:0] inst_rdata, data_rdata;
    logic        m_req, m_wr, m_addr_ok, m_data_ok;
    logic [31:0] m_addr, m_wdata, m_rdata;

    int total = 0;
    int bad   = 0;

    // Model: queue of issuers (1 = inst, 2 = data) and the requester that
    // currently owns the port after an un-accepted offer (0 = nobody).
    int q_ids[$];
    int owner = 0;
    bit exp_inst_aok, exp_data_aok;
    bit inst_pend, data_pend;

    always #5 clk = ~clk;

    sram_like_arbiter #(.OUTSTANDING(OUT), .ID_W(1)) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_addr(inst_addr), .inst_wdata(inst_wdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs are set after a falling edge; this compares outputs, then
    // advances the model over the rising edge and returns at the next fall.
    task automatic step(input string tag);
        int sel;
        bit sreq, full, exp_mreq, acc, pop;
        int head;
        #1;
        if (reset) begin
            chk({tag, ".rst.m_req"}, m_req, 0);
            chk({tag, ".rst.aok"}, {inst_addr_ok, data_addr_ok}, 0);
            chk({tag, ".rst.dok"}, {inst_data_ok, data_data_ok}, 0);
            chk({tag, ".rst.rdata"}, data_rdata, m_rdata);
            exp_inst_aok = 0;
            exp_data_aok = 0;
            @(posedge clk);
            q_ids.delete();
            owner = 0;
            @(negedge clk);
            return;
        end
        assert (!(owner == 1 && !inst_req)) else $error("protocol: inst request withdrawn during hold");
        assert (!(owner == 2 && !data_req)) else $error("protocol: data request withdrawn during hold");
        full = (q_ids.size() == OUT);
        if (owner == 0) sel = data_req ? 2 : (inst_req ? 1 : 0);
        else            sel = owner;
        sreq     = (sel == 1) ? inst_req : ((sel == 2) ? data_req : 1'b0);
        exp_mreq = sreq && !full;
        acc      = exp_mreq && m_addr_ok;
        pop      = m_data_ok && (q_ids.size() > 0);
        head     = (q_ids.size() > 0) ? q_ids[0] : 0;
        exp_inst_aok = acc && (sel == 1);
        exp_data_aok = acc && (sel == 2);

        chk({tag, ".m_req"}, m_req, exp_mreq);
        chk({tag, ".inst_addr_ok"}, inst_addr_ok, exp_inst_aok);
        chk({tag, ".data_addr_ok"}, data_addr_ok, exp_data_aok);
        chk({tag, ".inst_data_ok"}, inst_data_ok, pop && head == 1);
        chk({tag, ".data_data_ok"}, data_data_ok, pop && head == 2);
        chk({tag, ".inst_rdata"}, inst_rdata, m_rdata);
        chk({tag, ".data_rdata"}, data_rdata, m_rdata);
        if (exp_mreq) begin
            chk({tag, ".m_wr"},    m_wr,    (sel == 2) ? data_wr    : inst_wr);
            chk({tag, ".m_size"},  m_size,  (sel == 2) ? data_size  : inst_size);
            chk({tag, ".m_addr"},  m_addr,  (sel == 2) ? data_addr  : inst_addr);
            chk({tag, ".m_wdata"}, m_wdata, (sel == 2) ? data_wdata : inst_wdata);
        end
        @(posedge clk);
        if (pop) void'(q_ids.pop_front());
        if (acc) q_ids.push_back(sel);
        if (owner == 0 && sel != 0 && !full && !m_addr_ok) owner = sel;
        else if (owner != 0 && acc) owner = 0;
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_addr = '0; inst_wdata = '0;
        data_req = 0; data_wr = 0; data_size = 2'd2; data_addr = '0; data_wdata = '0;
        m_addr_ok = 0; m_data_ok = 0; m_rdata = '0;
    endtask

    // Let pending requests complete, then return everything outstanding.
    task automatic drain(input string tag);
        int n = 0;
        while ((inst_pend || data_pend || q_ids.size() > 0) && n < 40) begin
            if (!inst_pend) inst_req = 0;
            if (!data_pend) data_req = 0;
            m_addr_ok = 1;
            m_data_ok = 1;
            m_rdata   = $urandom;
            step(tag);
            inst_pend = inst_req && !exp_inst_aok;
            data_pend = data_req && !exp_data_aok;
            n++;
        end
        if (n == 40) chk({tag, ".drain_timeout"}, n, 0);
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        reset = 1;
        @(negedge clk);
        step("reset");
        reset = 0;
        step("idle");

        // Priority: data wins, inst follows.
        data_req = 1; data_addr = 32'h1000;
        inst_req = 1; inst_addr = 32'hBFC0_0000;
        m_addr_ok = 1;
        #1;
        chk("prio.c1.addr", m_addr, 32'h1000);
        chk("prio.c1.daok", data_addr_ok, 1);
        step("prio.c1");
        data_req = 0;
        #1;
        chk("prio.c2.addr", m_addr, 32'hBFC0_0000);
        chk("prio.c2.iaok", inst_addr_ok, 1);
        step("prio.c2");
        inst_req = 0;
        drain("prio.drain");

        // Grant hold: inst keeps the port while data arrives.
        inst_req = 1; inst_addr = 32'hBFC0_0040;
        m_addr_ok = 0;
        step("hold.c1");
        data_req = 1; data_addr = 32'h0000_2000;
        #1;
        chk("hold.c2.addr", m_addr, 32'hBFC0_0040);
        step("hold.c2");
        step("hold.c3");
        m_addr_ok = 1;
        #1;
        chk("hold.c4.addr", m_addr, 32'hBFC0_0040);
        chk("hold.c4.iaok", inst_addr_ok, 1);
        chk("hold.c4.daok", data_addr_ok, 0);
        step("hold.c4");
        inst_req = 0;
        #1;
        chk("hold.c5.addr", m_addr, 32'h0000_2000);
        chk("hold.c5.daok", data_addr_ok, 1);
        step("hold.c5");
        data_req = 0;
        drain("hold.drain");

        // Ordering: data, inst, data issued; returns steered in order.
        m_addr_ok = 1;
        data_req = 1; data_addr = 32'h100; step("ord.i1");
        data_req = 0; inst_req = 1; inst_addr = 32'h200; step("ord.i2");
        inst_req = 0; data_req = 1; data_addr = 32'h300; step("ord.i3");
        data_req = 0; m_addr_ok = 0; m_data_ok = 1;
        m_rdata = 32'h11;
        #1;
        chk("ord.r1.dok", {inst_data_ok, data_data_ok}, 2'b01);
        chk("ord.r1.rdata", data_rdata, 32'h11);
        step("ord.r1");
        m_rdata = 32'h22;
        #1;
        chk("ord.r2.dok", {inst_data_ok, data_data_ok}, 2'b10);
        chk("ord.r2.rdata", inst_rdata, 32'h22);
        step("ord.r2");
        m_rdata = 32'h33;
        #1;
        chk("ord.r3.dok", {inst_data_ok, data_data_ok}, 2'b01);
        chk("ord.r3.rdata", data_rdata, 32'h33);
        step("ord.r3");
        idle_inputs();
        step("ord.idle");

        // Full: four inst reads outstanding block the fifth.
        inst_req = 1; m_addr_ok = 1;
        for (int i = 0; i < OUT; i++) begin
            inst_addr = 32'h4000 + 32'(i * 4);
            step("full.fill");
        end
        inst_addr = 32'h4010;
        #1;
        chk("full.c5.m_req", m_req, 0);
        chk("full.c5.iaok", inst_addr_ok, 0);
        step("full.c5");
        m_data_ok = 1; m_rdata = 32'hAA;
        #1;
        chk("full.pop.iaok", inst_addr_ok, 0);
        chk("full.pop.idok", inst_data_ok, 1);
        step("full.pop");
        m_data_ok = 0;
        #1;
        chk("full.c7.iaok", inst_addr_ok, 1);
        chk("full.c7.addr", m_addr, 32'h4010);
        step("full.c7");
        inst_req = 0;
        drain("full.drain");

        // Write pass-through on the data side.
        data_req = 1; data_wr = 1; data_size = 2'd2;
        data_addr = 32'h2004; data_wdata = 32'hDEAD_BEEF; m_addr_ok = 1;
        #1;
        chk("wr.m_wr", m_wr, 1);
        chk("wr.m_size", m_size, 2);
        chk("wr.m_addr", m_addr, 32'h2004);
        chk("wr.m_wdata", m_wdata, 32'hDEAD_BEEF);
        step("wr.issue");
        idle_inputs();
        m_data_ok = 1;
        #1;
        chk("wr.ret.dok", {inst_data_ok, data_data_ok}, 2'b01);
        step("wr.ret");
        idle_inputs();

        // Reset with two transactions outstanding.
        inst_req = 1; m_addr_ok = 1;
        step("rst.a1");
        step("rst.a2");
        idle_inputs();
        reset = 1;
        step("rst.pulse");
        reset = 0;
        m_data_ok = 1;
        #1;
        chk("rst.after.dok", {inst_data_ok, data_data_ok}, 2'b00);
        step("rst.after");
        idle_inputs();
        inst_req = 1; inst_addr = 32'h5000; m_addr_ok = 1;
        #1;
        chk("rst.free.iaok", inst_addr_ok, 1);
        step("rst.free");
        idle_inputs();
        drain("rst.drain");

        // Random traffic obeying the hold-until-addr_ok rule.
        inst_pend = 0;
        data_pend = 0;
        for (int c = 0; c < 600; c++) begin
            if (!inst_pend) begin
                inst_req   = ($urandom_range(0, 1) == 1);
                inst_wr    = ($urandom_range(0, 7) == 0);
                inst_size  = 2'($urandom_range(0, 2));
                inst_addr  = $urandom;
                inst_wdata = $urandom;
            end
            if (!data_pend) begin
                data_req   = ($urandom_range(0, 2) == 0);
                data_wr    = 1'($urandom_range(0, 1));
                data_size  = 2'($urandom_range(0, 2));
                data_addr  = $urandom;
                data_wdata = $urandom;
            end
            m_addr_ok = ($urandom_range(0, 2) != 0);
            m_data_ok = ($urandom_range(0, 2) == 0);
            m_rdata   = $urandom;
            step("rand");
            inst_pend = inst_req && !exp_inst_aok;
            data_pend = data_req && !exp_data_aok;
        end
        drain("rand.drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sram_like_arbiter.md
Name: sram_like_arbiter

Overview:
- 2-to-1 arbiter: merges the inst-side and data-side sram-like masters of the CPU core onto one shared sram-like port.
- The shared port feeds the single sram-like-to-AXI bridge.
- Grants address phases by fixed priority (data over inst), holds each grant stable until addr_ok, and tracks outstanding transactions in an in-order ID FIFO.
- Routes each returning data_ok/rdata to the requester that issued it.

Parameters:
OUTSTANDING  4  max accepted-but-not-returned transactions; power of 2, 2..8
ID_W  1  width of source tag stored per outstanding transaction (0 = inst, 1 = data)

Ports:
clk  input  1  system clock, all logic rising-edge
reset  input  1  synchronous, active-high reset
inst_req  input  1  inst requester request
inst_wr  input  1  inst write flag (normally 0)
inst_size  input  2  inst size (0 = byte, 1 = half, 2 = word)
inst_addr  input  32  inst address
inst_wdata  input  32  inst write data
inst_addr_ok  output  1  inst address phase accepted
inst_data_ok  output  1  inst data phase complete
inst_rdata  output  32  inst read data
data_req  input  1  data requester request
data_wr  input  1  data write flag
data_size  input  2  data size
data_addr  input  32  data address
data_wdata  input  32  data write data
data_addr_ok  output  1  data address phase accepted
data_data_ok  output  1  data data phase complete
data_rdata  output  32  data read data
m_req  output  1  shared-port request
m_wr  output  1  shared-port write flag
m_size  output  2  shared-port size
m_addr  output  32  shared-port address
m_wdata  output  32  shared-port write data
m_addr_ok  input  1  shared-port address accepted
m_data_ok  input  1  shared-port data return, in issue order
m_rdata  input  32  shared-port read data

Behaviour:
- Grant FSM states: FREE, HOLD_INST, HOLD_DATA. Reset -> FREE.
- FREE, candidate selection:
  - data_req=1 -> data is candidate.
  - else inst_req=1 -> inst is candidate.
  - else no candidate.
- FREE, when a candidate exists and the FIFO is not full:
  - m_* is driven from the candidate combinationally.
  - m_addr_ok=1 in the same cycle -> accept; stay FREE.
  - m_addr_ok=0 -> go to HOLD_<candidate>.
- HOLD_x:
  - m_* is driven from x only, regardless of the other requester.
  - On m_addr_ok=1 -> accept; go to FREE.
  - Requesters hold req and payload stable until addr_ok (sram-like rule).
  - If x drops req anyway, m_req follows it to 0 and the FSM stays in HOLD_x. This is a protocol error; it is flagged by a bench assertion only.
- Accept cycle (m_req & m_addr_ok):
  - The granted requester's addr_ok=1 for exactly that cycle.
  - Its ID is pushed to the FIFO.
  - The other requester's addr_ok=0.
- FIFO full (count==OUTSTANDING):
  - m_req=0 and both addr_ok=0, even if m_data_ok pops in the same cycle. Push is blocked for that cycle.
  - A HOLD state is kept while full; its request is reissued once space exists.
- Data return:
  - m_data_ok=1 with FIFO non-empty -> data_ok goes to the head ID, and the FIFO pops.
  - <ID>_rdata=m_rdata (combinational); both rdata outputs always carry m_rdata.
  - The non-head requester's data_ok=0.
- m_data_ok=1 with FIFO empty: ignored, no output asserted. This covers stale returns after reset.
- Push and pop in the same cycle (not full): count unchanged, order preserved.
- Pointers are log2(OUTSTANDING) bits and wrap naturally. count is log2(OUTSTANDING)+1 bits.
- Zero-latency path: a transaction may be accepted and returned in the same cycle only if the FIFO is non-empty for an earlier ID. A same-cycle data_ok for the entry being pushed is not supported (the slave never does this).
- Reset values:
  - FSM=FREE, FIFO empty (wr/rd ptr=0, count=0).
  - All outputs 0 except the rdata buses, which follow m_rdata.
  - A reset mid-transaction discards all outstanding IDs.
- No combinational path from m_addr_ok to m_req.

Decomposition:
- Package sram_like_pkg:
  - grant state encoding (FREE/HOLD_INST/HOLD_DATA).
  - ID constants ID_INST=0, ID_DATA=1.
  - size constants SIZE_B/H/W.
- Sub-module id_fifo: synchronous FIFO (OUTSTANDING x ID_W) with push, pop, full, empty and head outputs, synchronous active-high reset.

Test Plan:
- Priority: inst_req and data_req both high with data_addr=0x1000, inst_addr=0xBFC00000, m_addr_ok=1 -> cycle 1: m_addr=0x1000 and data_addr_ok=1. Cycle 2: m_addr=0xBFC00000 and inst_addr_ok=1.
- Grant hold: inst_req alone with m_addr_ok held 0 for 3 cycles, data_req rises in cycle 2 -> m_addr stays the inst address until m_addr_ok. Data is granted the following cycle.
- Ordering:
  - Issue data read, inst read, data read; return m_rdata 0x11, 0x22, 0x33 on consecutive m_data_ok.
  - Expect data_data_ok(0x11), inst_data_ok(0x22), data_data_ok(0x33).
  - The off-head data_ok stays 0 in each cycle.
- Full: OUTSTANDING=4, accept 4 inst reads with no data_ok -> 5th: m_req=0 and inst_addr_ok=0. One m_data_ok -> the 5th is accepted the next cycle. A pop in the full cycle itself still blocks the push.
- Write pass-through: data_wr=1, size=2, addr=0x2004, wdata=0xDEADBEEF -> the identical payload appears on m_*. data_data_ok returns on m_data_ok.
- Reset mid-op: 2 outstanding, assert reset 1 cycle, then m_data_ok=1 -> no data_ok asserted. FSM=FREE and FIFO empty after reset.
